seq_stream_checker: RTL and testbench

- Downstream consumer of the registered valid/data stream produced by the incrementing-counter source stage (ovalid/odata).
- Locks onto the first valid word, then checks that every following valid word equals the previous word plus STEP, modulo 2^DATA_WIDTH.
- Keeps pass, error and sample statistics, and captures the first mismatch for debug readout and bench self-checking.

---
 rtl/seq_stream_checker_pkg.sv | 29 ++
 rtl/seq_stream_checker_sat_counter.sv | 41 ++++
 rtl/seq_stream_checker.sv | 156 +++++++++++++++
 tb/tb_seq_stream_checker.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_stream_checker_pkg.sv
// -----------------------------------------------------------------------------
// seq_stream_checker_pkg
//   Shared definitions for the sequence stream checker:
//     - chk_state_t : checker state encoding (ST_IDLE, ST_RUN)
//     - SAT_MAX_W   : widest counter the saturating helper supports
//     - sat_inc()   : saturating increment at a caller-chosen width
// -----------------------------------------------------------------------------
package seq_stream_checker_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,  // waiting for the first valid word to lock onto
    ST_RUN  = 1'b1   // locked, checking each valid word against expected
  } chk_state_t;

  localparam int unsigned SAT_MAX_W = 64;

  // Increment 'value' by one, holding at the all-ones value of a 'width'-bit
  // counter. Operands are carried at SAT_MAX_W bits so one function serves
  // every counter width; callers zero-extend in and slice the result back.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] value,
    input int unsigned          width
  );
    logic [SAT_MAX_W-1:0] max_val;
    max_val = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
    return (value >= max_val) ? max_val : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_stream_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up counter that saturates at all-ones instead of wrapping.
//   Ports:
//     sys_clk  in   clock, rising edge
//     sys_rst  in   asynchronous active-high reset (count -> 0)
//     clr      in   synchronous clear (count -> 0), wins over inc
//     inc      in   increment by one this cycle
//     cnt      out  current count, WIDTH bits
// -----------------------------------------------------------------------------
module sat_counter
  import seq_stream_checker_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [SAT_MAX_W-1:0] cnt_inc_wide;

  always_comb begin
    cnt_inc_wide = sat_inc(SAT_MAX_W'(cnt), WIDTH);
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others, independent of block evaluation order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc_wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_stream_checker.sv
// -----------------------------------------------------------------------------
// seq_stream_checker
//   Consumes a valid/data stream from an incrementing-counter source. Locks on
//   the first valid word, then checks every following valid word equals the
//   previous expected value plus STEP (modulo 2^DATA_WIDTH). Keeps saturating
//   sample/pass/error statistics and captures the first mismatch.
//   Ports:
//     sys_clk        in   clock, rising edge
//     sys_rst        in   asynchronous active-high reset
//     clear          in   synchronous clear of state, statistics and capture
//     ivalid         in   input word valid (no backpressure)
//     idata          in   input word, DATA_WIDTH bits
//     locked         out  1 while in ST_RUN
//     sample_cnt     out  valid words accepted since reset/clear
//     pass_cnt       out  words equal to expected
//     err_cnt        out  words different from expected
//     err_flag       out  sticky, set on the first mismatch
//     first_err_idx  out  0-based sample index of the first mismatch
//     first_err_exp  out  expected value at the first mismatch
//     first_err_got  out  received value at the first mismatch
//   All outputs are registered; nothing passes combinationally from inputs.
// -----------------------------------------------------------------------------
module seq_stream_checker
  import seq_stream_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned STEP       = 1,
  parameter bit          RESYNC     = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  clear,
  input  logic                  ivalid,
  input  logic [DATA_WIDTH-1:0] idata,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  sample_cnt,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_got
);

  // Truncating STEP here makes every expected-value sum wrap at DATA_WIDTH.
  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);

  chk_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] expected, expected_nxt;
  logic                  err_flag_nxt;
  logic [CNT_WIDTH-1:0]  first_err_idx_nxt;
  logic [DATA_WIDTH-1:0] first_err_exp_nxt;
  logic [DATA_WIDTH-1:0] first_err_got_nxt;
  logic                  sample_inc, pass_inc, err_inc;
  logic                  mismatch;

  // NOTE: every signal written in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt         = state;
    expected_nxt      = expected;
    err_flag_nxt      = err_flag;
    first_err_idx_nxt = first_err_idx;
    first_err_exp_nxt = first_err_exp;
    first_err_got_nxt = first_err_got;
    sample_inc        = 1'b0;
    pass_inc          = 1'b0;
    err_inc           = 1'b0;
    mismatch          = (idata != expected);

    if (clear) begin
      // Clear wins over a simultaneous valid word; that word is discarded.
      state_nxt         = ST_IDLE;
      expected_nxt      = '0;
      err_flag_nxt      = 1'b0;
      first_err_idx_nxt = '0;
      first_err_exp_nxt = '0;
      first_err_got_nxt = '0;
    end else if (ivalid) begin
      sample_inc = 1'b1;
      case (state)
        ST_IDLE: begin
          // Lock word is counted as a sample only, never as pass or error.
          state_nxt    = ST_RUN;
          expected_nxt = idata + STEP_W;
        end
        ST_RUN: begin
          if (mismatch) begin
            err_inc      = 1'b1;
            err_flag_nxt = 1'b1;
            if (!err_flag) begin
              // sample_cnt is the 0-based index of this word; if it has
              // saturated, the captured index sticks at all-ones.
              first_err_idx_nxt = sample_cnt;
              first_err_exp_nxt = expected;
              first_err_got_nxt = idata;
            end
          end else begin
            pass_inc = 1'b1;
          end
          expected_nxt = (mismatch && RESYNC) ? idata + STEP_W
                                              : expected + STEP_W;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      expected      <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      state         <= state_nxt;
      expected      <= expected_nxt;
      err_flag      <= err_flag_nxt;
      first_err_idx <= first_err_idx_nxt;
      first_err_exp <= first_err_exp_nxt;
      first_err_got <= first_err_got_nxt;
    end
  end

  assign locked = (state == ST_RUN);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_sample_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (clear),
    .inc     (sample_inc),
    .cnt     (sample_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pass_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (clear),
    .inc     (pass_inc),
    .cnt     (pass_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (clear),
    .inc     (err_inc),
    .cnt     (err_cnt)
  );

endmodule

// File: tb/tb_seq_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_stream_checker
//   Drives directed word sequences into two checkers sharing one input stream:
//   dut (RESYNC=1) and dut_nr (RESYNC=0). Each driven cycle pushes the expected
//   post-edge outputs of both into a queue; a monitor pops one entry per clock
//   and compares. Hand-computed totals are checked at the end of each sequence.
// -----------------------------------------------------------------------------
module tb_seq_stream_checker;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        clear;
  logic        ivalid;
  logic [31:0] idata;

  logic        locked,  locked_nr;
  logic [31:0] sample_cnt, pass_cnt, err_cnt;
  logic [31:0] sample_cnt_nr, pass_cnt_nr, err_cnt_nr;
  logic        err_flag, err_flag_nr;
  logic [31:0] first_err_idx, first_err_exp, first_err_got;
  logic [31:0] first_err_idx_nr, first_err_exp_nr, first_err_got_nr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  seq_stream_checker #(.DATA_WIDTH(32), .CNT_WIDTH(32), .STEP(1), .RESYNC(1'b1)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .clear         (clear),
    .ivalid        (ivalid),
    .idata         (idata),
    .locked        (locked),
    .sample_cnt    (sample_cnt),
    .pass_cnt      (pass_cnt),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag),
    .first_err_idx (first_err_idx),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

  seq_stream_checker #(.DATA_WIDTH(32), .CNT_WIDTH(32), .STEP(1), .RESYNC(1'b0)) dut_nr (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .clear         (clear),
    .ivalid        (ivalid),
    .idata         (idata),
    .locked        (locked_nr),
    .sample_cnt    (sample_cnt_nr),
    .pass_cnt      (pass_cnt_nr),
    .err_cnt       (err_cnt_nr),
    .err_flag      (err_flag_nr),
    .first_err_idx (first_err_idx_nr),
    .first_err_exp (first_err_exp_nr),
    .first_err_got (first_err_got_nr)
  );

  // Reference state of one checker, advanced once per driven cycle.
  typedef struct packed {
    logic        locked;
    logic [31:0] expected;
    logic [31:0] sample;
    logic [31:0] pass;
    logic [31:0] err;
    logic        flag;
    logic [31:0] idx;
    logic [31:0] fexp;
    logic [31:0] fgot;
  } model_t;

  typedef struct packed {
    model_t r1;  // RESYNC=1 instance
    model_t r0;  // RESYNC=0 instance
  } snap_t;

  snap_t  exp_q[$];
  model_t m1 = '0;
  model_t m0 = '0;

  function automatic logic [31:0] sat32(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic model_t model_next(input model_t m, input logic v,
                                        input logic [31:0] d, input logic c,
                                        input bit resync);
    model_t n;
    logic   mis;
    n = m;
    if (c) begin
      n = '0;
    end else if (v && !m.locked) begin
      n.locked   = 1'b1;
      n.expected = d + 32'd1;
      n.sample   = 32'd1;
    end else if (v) begin
      mis = (d != m.expected);
      if (mis) begin
        n.err  = sat32(m.err);
        n.flag = 1'b1;
        if (!m.flag) begin
          n.idx  = m.sample;
          n.fexp = m.expected;
          n.fgot = d;
        end
      end else begin
        n.pass = sat32(m.pass);
      end
      n.sample   = sat32(m.sample);
      n.expected = (mis && resync) ? d + 32'd1 : m.expected + 32'd1;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One driven cycle: inputs change at the falling edge, the rising edge
  // samples them, and the expected post-edge outputs go on the queue.
  task automatic drive(input logic v, input logic [31:0] d, input logic c);
    @(negedge sys_clk);
    ivalid = v;
    idata  = d;
    clear  = c;
    m1 = model_next(m1, v, d, c, 1'b1);
    m0 = model_next(m0, v, d, c, 1'b0);
    exp_q.push_back('{r1: m1, r0: m0});
  endtask

  task automatic drive_seq(input logic [31:0] words[]);
    foreach (words[i]) drive(1'b1, words[i], 1'b0);
    drive(1'b0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge sys_clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic hand(input string tag, input logic lk, input logic [31:0] s,
                      input logic [31:0] p, input logic [31:0] e, input logic f);
    check({tag, ".locked"},     64'(locked),     64'(lk));
    check({tag, ".sample_cnt"}, 64'(sample_cnt), 64'(s));
    check({tag, ".pass_cnt"},   64'(pass_cnt),   64'(p));
    check({tag, ".err_cnt"},    64'(err_cnt),    64'(e));
    check({tag, ".err_flag"},   64'(err_flag),   64'(f));
  endtask

  task automatic cmp_one(input string tag, input model_t m, input logic lk,
                         input logic [31:0] s, input logic [31:0] p,
                         input logic [31:0] e, input logic f,
                         input logic [31:0] ix, input logic [31:0] fx,
                         input logic [31:0] fg);
    check({tag, ".locked"},        64'(lk), 64'(m.locked));
    check({tag, ".sample_cnt"},    64'(s),  64'(m.sample));
    check({tag, ".pass_cnt"},      64'(p),  64'(m.pass));
    check({tag, ".err_cnt"},       64'(e),  64'(m.err));
    check({tag, ".err_flag"},      64'(f),  64'(m.flag));
    check({tag, ".first_err_idx"}, 64'(ix), 64'(m.idx));
    check({tag, ".first_err_exp"}, 64'(fx), 64'(m.fexp));
    check({tag, ".first_err_got"}, 64'(fg), 64'(m.fgot));
  endtask

  // Monitor: one queue entry per rising edge, compared 1 ns after it.
  initial begin
    snap_t s;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        cmp_one("mon_resync",   s.r1, locked, sample_cnt, pass_cnt, err_cnt,
                err_flag, first_err_idx, first_err_exp, first_err_got);
        cmp_one("mon_noresync", s.r0, locked_nr, sample_cnt_nr, pass_cnt_nr,
                err_cnt_nr, err_flag_nr, first_err_idx_nr, first_err_exp_nr,
                first_err_got_nr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    clear   = 1'b0;
    ivalid  = 1'b0;
    idata   = '0;

    // Reset state.
    #20;
    hand("reset", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check("reset.first_err_idx", 64'(first_err_idx), 64'd0);
    #25 sys_rst = 1'b0;  // released at 45 ns

    // Counter 0..9: locks on 0, nine passes.
    drive_seq('{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9});
    drain();
    hand("count10", 1'b1, 32'd10, 32'd9, 32'd0, 1'b0);

    // Jump in the stream: resync recovers after one error, no-resync does not.
    drive(1'b0, 32'd0, 1'b1);
    drive_seq('{32'd5, 32'd6, 32'd7, 32'd20, 32'd21, 32'd22});
    drain();
    hand("jump", 1'b1, 32'd6, 32'd4, 32'd1, 1'b1);
    check("jump.first_err_idx", 64'(first_err_idx), 64'd3);
    check("jump.first_err_exp", 64'(first_err_exp), 64'd8);
    check("jump.first_err_got", 64'(first_err_got), 64'd20);
    check("jump_nr.err_cnt",    64'(err_cnt_nr),    64'd3);
    check("jump_nr.pass_cnt",   64'(pass_cnt_nr),   64'd2);

    // Data wrap through all-ones is a legal increment.
    drive(1'b0, 32'd0, 1'b1);
    drive_seq('{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    drain();
    hand("wrap", 1'b1, 32'd4, 32'd3, 32'd0, 1'b0);

    // Idle cycles between valid words are ignored.
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i), 1'b0);
      drive(1'b0, 32'hDEAD_BEEF, 1'b0);
    end
    drain();
    hand("gaps", 1'b1, 32'd4, 32'd3, 32'd0, 1'b0);

    // Two errors, then clear together with a valid word: clear wins.
    drive(1'b0, 32'd0, 1'b1);
    drive_seq('{32'd0, 32'd1, 32'd9, 32'd10, 32'd3});
    drain();
    hand("two_err", 1'b1, 32'd5, 32'd2, 32'd2, 1'b1);
    check("two_err.first_err_idx", 64'(first_err_idx), 64'd2);
    drive(1'b1, 32'd4, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    drain();
    hand("clear_valid", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    check("clear_valid.first_err_got", 64'(first_err_got), 64'd0);
    drive_seq('{32'd100});
    drain();
    hand("relock", 1'b1, 32'd1, 32'd0, 32'd0, 1'b0);

    // Asynchronous reset mid-stream after four words.
    drive(1'b0, 32'd0, 1'b1);
    drive_seq('{32'd0, 32'd1, 32'd2, 32'd3});
    drain();
    #2 sys_rst = 1'b1;
    #1;
    hand("async_rst", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    m1 = '0;
    m0 = '0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    drive_seq('{32'd7, 32'd8});
    drain();
    hand("after_rst", 1'b1, 32'd2, 32'd1, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
